// File: rtl/rns_reverse_seq_if.sv
// Handshake bundle for the RNS reverse-converter sequencer: residue tuple in,
// reduced 28-bit binary result out, each over its own valid/ready pair.
interface rns_reverse_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  r1;
    logic [7:0]  r2;
    logic [14:0] r3;
    logic [16:0] r4;
    logic        out_valid;
    logic        out_ready;
    logic [27:0] result;

    // Upstream/downstream side: offers tuples, consumes results.
    modport master (
        output in_valid, r1, r2, r3, r4, out_ready,
        input  in_ready, out_valid, result
    );

    // Sequencer side.
    modport slave (
        input  in_valid, r1, r2, r3, r4, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/rns_reverse_seq.sv
// Sequencer for the 4-channel RNS reverse converter (n=7, p=3). Holds a residue
// tuple on the converter inputs, captures the converter's carry-save pair and
// finishes the end-around-carry addition mod 2^28-1 on one 7-bit serial adder.
module rns_reverse_seq #(
    parameter int CHUNK_W = 7,
    parameter int NCHUNK  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rns_reverse_seq_if.slave            bus,
    output logic [6:0]                  conv_r1,
    output logic [7:0]                  conv_r2,
    output logic [14:0]                 conv_r3,
    output logic [16:0]                 conv_r4,
    input  logic [CHUNK_W*NCHUNK-1:0]   conv_s,
    input  logic [CHUNK_W*NCHUNK-1:0]   conv_c,
    output logic                        busy
);
    localparam int W     = CHUNK_W * NCHUNK;
    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPT,
        S_ADD,
        S_WRAP,
        S_DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     s_reg;
    logic [W-1:0]     c_reg;
    logic [W-1:0]     acc;
    logic             cf;
    logic [IDX_W-1:0] idx;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [W-1:0]     result_q;

    logic [CHUNK_W-1:0] s_chunk;
    logic [CHUNK_W-1:0] c_chunk;
    logic [CHUNK_W:0]   chunk_sum;
    logic [W-1:0]       wrap_sum;
    logic [W-1:0]       result_next;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

    // The single shared 7-bit slice adder plus the final carry fold and normalisation.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        s_chunk     = '0;
        c_chunk     = '0;
        chunk_sum   = '0;
        wrap_sum    = '0;
        result_next = '0;
        s_chunk     = s_reg[idx*CHUNK_W +: CHUNK_W];
        c_chunk     = c_reg[idx*CHUNK_W +: CHUNK_W];
        chunk_sum   = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK_W{1'b0}}, cf};
        // acc + cf cannot overflow: a set cf means acc <= 2^W-2.
        wrap_sum    = acc + {{(W-1){1'b0}}, cf};
        // All-ones is the redundant encoding of zero mod 2^W-1.
        result_next = (wrap_sum == {W{1'b1}}) ? '0 : wrap_sum;
    end

    // Control FSM and all datapath registers, with registered handshake outputs.
    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every register, datapath included, so nothing in flight survives.
        if (!rst_n) begin
            state       <= S_IDLE;
            s_reg       <= '0;
            c_reg       <= '0;
            acc         <= '0;
            cf          <= 1'b0;
            idx         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            busy        <= 1'b0;
            conv_r1     <= '0;
            conv_r2     <= '0;
            conv_r3     <= '0;
            conv_r4     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        conv_r1    <= bus.r1;
                        conv_r2    <= bus.r2;
                        conv_r3    <= bus.r3;
                        conv_r4    <= bus.r4;
                        in_ready_q <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    s_reg <= conv_s;
                    // The carry bit of weight 2^W folds back to weight 2^0.
                    c_reg <= {conv_c[W-2:0], conv_c[W-1]};
                    cf    <= 1'b0;
                    idx   <= '0;
                    state <= S_ADD;
                end
                S_ADD: begin
                    acc[idx*CHUNK_W +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
                    cf <= chunk_sum[CHUNK_W];
                    if (idx == LAST_IDX) begin
                        state <= S_WRAP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_WRAP: begin
                    result_q <= result_next;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle presents the already-registered result.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rns_reverse_seq.sv
// Directed bench for rns_reverse_seq. The converter is stubbed: the bench drives
// conv_s/conv_c directly and expects (conv_s + 2*conv_c) mod 2^28-1.
module tb_rns_reverse_seq;
    localparam longint MOD = 64'd268435455;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  conv_r1;
    logic [7:0]  conv_r2;
    logic [14:0] conv_r3;
    logic [16:0] conv_r4;
    logic [27:0] conv_s;
    logic [27:0] conv_c;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    rns_reverse_seq_if bus ();

    rns_reverse_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .conv_r1 (conv_r1),
        .conv_r2 (conv_r2),
        .conv_r3 (conv_r3),
        .conv_r4 (conv_r4),
        .conv_s  (conv_s),
        .conv_c  (conv_c),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Runs one transaction; all tasks start and end just after a falling edge.
    task automatic run_txn(input logic [6:0] a, input logic [7:0] b, input logic [14:0] c,
                           input logic [16:0] d, input logic [27:0] s, input logic [27:0] cv,
                           input int hold, output logic [27:0] res, output int lat, output bit ok);
        int guard;
        ok = 1'b1; lat = 0; res = '0;
        conv_s = s; conv_c = cv;
        bus.r1 = a; bus.r2 = b; bus.r3 = c; bus.r4 = d;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk); guard++;
        end
        if (!bus.in_ready) ok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (ok) begin
            guard = 0;
            do begin
                @(posedge clk); lat++;
                @(negedge clk);
            end while (!bus.out_valid && lat < 50);
            if (!bus.out_valid) ok = 1'b0;
            res = bus.result;
            repeat (hold) @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.r1 = '0; bus.r2 = '0; bus.r3 = '0; bus.r4 = '0;
        conv_s = '0; conv_c = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     bus.in_ready, bus.out_valid, busy);
        else n_pass++;
        n_checks++;
        if (bus.result !== 28'h0 || conv_r1 !== 7'h0 || conv_r2 !== 8'h0 ||
            conv_r3 !== 15'h0 || conv_r4 !== 17'h0)
            $display("FAIL reset_regs: result=%h r=%h/%h/%h/%h, want all 0",
                     bus.result, conv_r1, conv_r2, conv_r3, conv_r4);
        else n_pass++;
    endtask

    task automatic test_zero_latency();
        logic [27:0] res; int lat; bit ok;
        run_txn(7'd0, 8'd0, 15'd0, 17'd0, 28'h0, 28'h0, 0, res, lat, ok);
        n_checks++;
        if (!ok || lat != 7)
            $display("FAIL zero_latency: ok=%0d latency=%0d, want 1 7", ok, lat);
        else n_pass++;
        n_checks++;
        if (res !== 28'h0) $display("FAIL zero_result: got %h want 0000000", res);
        else n_pass++;
    endtask

    task automatic test_vectors();
        logic [27:0] vs [7];
        logic [27:0] vc [7];
        logic [27:0] ve [7];
        logic [27:0] res; int lat; bit ok;
        vs[0] = 28'hFFFFFFF; vc[0] = 28'h0000000; ve[0] = 28'h0000000; // normalises all-ones
        vs[1] = 28'hFFFFFFF; vc[1] = 28'h0000001; ve[1] = 28'h0000002; // carry out of slice 3
        vs[2] = 28'h0000005; vc[2] = 28'h8000000; ve[2] = 28'h0000006; // weight 2^28 wraps
        vs[3] = 28'h000007F; vc[3] = 28'h0000001; ve[3] = 28'h0000081; // slice 0 -> 1 carry
        vs[4] = 28'hFFFFFFE; vc[4] = 28'h0000000; ve[4] = 28'hFFFFFFE; // largest reduced value
        vs[5] = 28'h1234567; vc[5] = 28'h0000010; ve[5] = 28'h1234587;
        vs[6] = 28'h0000000; vc[6] = 28'h7FFFFFF; ve[6] = 28'hFFFFFFE; // carry vector alone
        for (int i = 0; i < 7; i++) begin
            run_txn(7'(i), 8'(i + 1), 15'(i + 2), 17'(i + 3), vs[i], vc[i], i % 3, res, lat, ok);
            n_checks++;
            if (!ok || res !== ve[i])
                $display("FAIL vector_%0d: ok=%0d got %h want %h", i, ok, res, ve[i]);
            else n_pass++;
        end
        n_checks++;
        if (conv_r1 !== 7'd6 || conv_r2 !== 8'd7 || conv_r3 !== 15'd8 || conv_r4 !== 17'd9)
            $display("FAIL conv_hold: r=%0d/%0d/%0d/%0d want 6/7/8/9",
                     conv_r1, conv_r2, conv_r3, conv_r4);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [27:0] s, c, res; longint exp; int lat; bit ok; int bad;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            s = 28'($urandom); c = 28'($urandom);
            exp = (longint'(s) + 2 * longint'(c)) % MOD;
            run_txn(7'($urandom), 8'($urandom), 15'($urandom), 17'($urandom), s, c,
                    $urandom_range(0, 3), res, lat, ok);
            if (!ok || res !== 28'(exp)) begin
                bad++;
                $display("FAIL random_%0d: s=%h c=%h got %h want %h", i, s, c, res, 28'(exp));
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL random_set: %0d bad of 40, want 0", bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int guard; bit moved; bit unstable; bit ready_seen;
        conv_s = 28'h0000003; conv_c = 28'h0;
        bus.r1 = 7'h11; bus.r2 = 8'h22; bus.r3 = 15'h333; bus.r4 = 17'h444;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.r1 = 7'h55; bus.r2 = 8'h66; bus.r3 = 15'h777; bus.r4 = 17'h888;
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(negedge clk); guard++;
        end
        n_checks++;
        if (!bus.out_valid) $display("FAIL bp_timeout: out_valid never rose");
        else n_pass++;
        unstable = 1'b0; ready_seen = 1'b0; moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.result !== 28'h3 || bus.out_valid !== 1'b1) unstable = 1'b1;
            if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
            if (conv_r1 !== 7'h11) moved = 1'b1;
        end
        n_checks++;
        if (unstable) $display("FAIL bp_stable: result=%h out_valid=%b want 0000003 1",
                               bus.result, bus.out_valid);
        else n_pass++;
        n_checks++;
        if (ready_seen || moved) $display("FAIL bp_no_accept: in_ready_seen=%0d conv_r1=%h want 0 11",
                                          ready_seen, conv_r1);
        else n_pass++;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (conv_r1 !== 7'h55 || conv_r4 !== 17'h888 || bus.in_ready !== 1'b0)
            $display("FAIL next_accept: conv_r1=%h conv_r4=%h in_ready=%b want 55 888 0",
                     conv_r1, conv_r4, bus.in_ready);
        else n_pass++;
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(negedge clk); guard++;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit spurious;
        conv_s = 28'h0ABCDEF; conv_c = 28'h0000101;
        bus.r1 = 7'h7; bus.r2 = 8'h8; bus.r3 = 15'h9; bus.r4 = 17'hA;
        bus.in_valid = 1'b1;
        @(posedge clk);                 // accept
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);      // CAPT, idx 0, idx 1
        @(negedge clk);
        rst_n = 1'b0;                   // edge that would process idx 2
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.result !== 28'h0)
            $display("FAIL mid_reset: in_ready=%b out_valid=%b busy=%b result=%h want 1 0 0 0000000",
                     bus.in_ready, bus.out_valid, busy, bus.result);
        else n_pass++;
        spurious = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) spurious = 1'b1;
        end
        n_checks++;
        if (spurious) $display("FAIL mid_reset_quiet: stale transaction resumed, want idle");
        else n_pass++;
    endtask

    task automatic test_recovery();
        logic [27:0] res; int lat; bit ok;
        run_txn(7'd1, 8'd2, 15'd3, 17'd4, 28'h0000100, 28'h0000080, 1, res, lat, ok);
        n_checks++;
        if (!ok || lat != 7 || res !== 28'h0000200)
            $display("FAIL recovery: ok=%0d latency=%0d result=%h want 1 7 0000200", ok, lat, res);
        else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_zero_latency();
        test_vectors();
        test_back_to_back();
        test_mid_reset();
        test_recovery();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
